// File: rtl/wb_queue_pkg.sv
// Shared types and sizes for the writeback queue: entry layout, pointer/count widths
// and the pointer-to-slot helper.
package wb_queue_pkg;

   localparam int WBQ_DTYPE = 8;
   localparam int WBQ_NREGS = 4;
   localparam int WBQ_DEPTH = 4;

   localparam int ADDR_W = $clog2(WBQ_NREGS);
   localparam int PTR_W  = $clog2(WBQ_DEPTH) + 1;
   localparam int IDX_W  = PTR_W - 1;
   localparam int CNT_W  = $clog2(WBQ_DEPTH + 1);

   typedef struct packed {
      logic [ADDR_W-1:0]    addr;
      logic [WBQ_DTYPE-1:0] data;
   } wbq_entry_t;

   // Pointers carry a wrap bit; the storage slot is the pointer modulo DEPTH.
   function automatic logic [IDX_W-1:0] ptr_idx(input logic [PTR_W-1:0] p);
      return IDX_W'(p % PTR_W'(WBQ_DEPTH));
   endfunction

endpackage

// File: rtl/wbq_lookup.sv
// Youngest-match search over the valid queue entries (head .. head+count-1).
// Later (younger) matches overwrite earlier ones, so the last hit in the scan wins.
module wbq_lookup
   import wb_queue_pkg::*;
#(
   parameter int DEPTH = WBQ_DEPTH
) (
   input  wbq_entry_t           entries [DEPTH],
   input  logic [PTR_W-1:0]     head,
   input  logic [CNT_W-1:0]     count,
   input  logic [ADDR_W-1:0]    lk_addr,
   output logic                 lk_hit,
   output logic [WBQ_DTYPE-1:0] lk_data
);

   always_comb begin
      lk_hit  = 1'b0;
      lk_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if ((CNT_W'(i) < count) &&
             (entries[ptr_idx(head + PTR_W'(i))].addr == lk_addr)) begin
            lk_hit  = 1'b1;
            lk_data = entries[ptr_idx(head + PTR_W'(i))].data;
         end
      end
   end

endmodule

// File: rtl/writeback_queue.sv
// Two-pipe result queue feeding a single register-file write port, one drain per cycle.
// Optional WB_QUEUE_BYPASS_EN: enq0 goes straight to the write port when the queue is empty.
module writeback_queue
   import wb_queue_pkg::*;
#(
   parameter int DTYPE = WBQ_DTYPE,
   parameter int NREGS = WBQ_NREGS,
   parameter int DEPTH = WBQ_DEPTH
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enq0_val,
   output logic                     enq0_rdy,
   input  logic [$clog2(NREGS)-1:0] enq0_addr,
   input  logic [DTYPE-1:0]         enq0_data,
   input  logic                     enq1_val,
   output logic                     enq1_rdy,
   input  logic [$clog2(NREGS)-1:0] enq1_addr,
   input  logic [DTYPE-1:0]         enq1_data,
   output logic                     wr_call,
   output logic [$clog2(NREGS)-1:0] wr_addr,
   output logic [DTYPE-1:0]         wr_data,
   input  logic [$clog2(NREGS)-1:0] lk_addr,
   output logic                     lk_hit,
   output logic [DTYPE-1:0]         lk_data
);

   wbq_entry_t       mem [DEPTH];
   logic [PTR_W-1:0] head, tail, tail1;
   logic [CNT_W-1:0] count, space, n_st;
   logic             fire0, fire1, bypass, store0, drain;
   wbq_entry_t       head_e;

   // Ready is a function of the registered count only; reset forces both low.
   assign space    = CNT_W'(DEPTH) - count;
   assign enq0_rdy = reset && (space >= CNT_W'(1));
   assign enq1_rdy = reset && (space >= CNT_W'(2));

   assign fire0 = enq0_val && enq0_rdy;
   assign fire1 = enq1_val && enq1_rdy;
   assign drain = (count != '0);

`ifdef WB_QUEUE_BYPASS_EN
   assign bypass = fire0 && (count == '0);
`else
   assign bypass = 1'b0;
`endif

   assign store0 = fire0 && !bypass;
   assign n_st   = CNT_W'(store0) + CNT_W'(fire1);
   // Pipe 0 is older: it takes tail, pipe 1 takes the next slot when both store.
   assign tail1  = tail + PTR_W'(store0);

   always_ff @(posedge clk) begin
      if (store0) begin
         mem[ptr_idx(tail)].addr <= enq0_addr;
         mem[ptr_idx(tail)].data <= enq0_data;
      end
      if (fire1) begin
         mem[ptr_idx(tail1)].addr <= enq1_addr;
         mem[ptr_idx(tail1)].data <= enq1_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + PTR_W'(drain);
         tail  <= tail + PTR_W'(n_st);
         count <= count + n_st - CNT_W'(drain);
      end
   end

   assign head_e = mem[ptr_idx(head)];

   always_comb begin
      wr_call = 1'b0;
      wr_addr = '0;
      wr_data = '0;
`ifdef WB_QUEUE_BYPASS_EN
      if (bypass) begin
         wr_call = 1'b1;
         wr_addr = enq0_addr;
         wr_data = enq0_data;
      end else
`endif
      if (drain) begin
         wr_call = 1'b1;
         wr_addr = head_e.addr;
         wr_data = head_e.data;
      end
   end

   // Same-cycle enqueues are not yet in count, so lookup never sees them.
   wbq_lookup #(.DEPTH(DEPTH)) u_lookup (
      .entries (mem),
      .head    (head),
      .count   (count),
      .lk_addr (lk_addr),
      .lk_hit  (lk_hit),
      .lk_data (lk_data)
   );

endmodule

// File: tb/tb_writeback_queue.sv
// Self-checking bench for writeback_queue: scoreboard model plus table-driven ordering vectors.
module tb_writeback_queue;

   localparam int DT = 8;
   localparam int NR = 4;
   localparam int DP = 4;
   localparam int AW = 2;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          enq0_val = 1'b0, enq1_val = 1'b0;
   logic          enq0_rdy, enq1_rdy;
   logic [AW-1:0] enq0_addr = '0, enq1_addr = '0, lk_addr = '0;
   logic [DT-1:0] enq0_data = '0, enq1_data = '0;
   logic          wr_call, lk_hit;
   logic [AW-1:0] wr_addr;
   logic [DT-1:0] wr_data, lk_data;

   writeback_queue #(.DTYPE(DT), .NREGS(NR), .DEPTH(DP)) dut (
      .clk       (clk),
      .reset     (reset),
      .enq0_val  (enq0_val),
      .enq0_rdy  (enq0_rdy),
      .enq0_addr (enq0_addr),
      .enq0_data (enq0_data),
      .enq1_val  (enq1_val),
      .enq1_rdy  (enq1_rdy),
      .enq1_addr (enq1_addr),
      .enq1_data (enq1_data),
      .wr_call   (wr_call),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .lk_addr   (lk_addr),
      .lk_hit    (lk_hit),
      .lk_data   (lk_data)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DT-1:0] data;
   } ent_t;

   typedef struct {
      logic          v0;
      logic [AW-1:0] a0;
      logic [DT-1:0] d0;
      logic          v1;
      logic [AW-1:0] a1;
      logic [DT-1:0] d1;
      logic [DT-1:0] exp_wr0;
      logic [DT-1:0] exp_wr1;
   } vec_t;

   ent_t          sb[$];
   logic [DT-1:0] wlog[$];
   int            n_tests = 0;
   int            n_fail  = 0;
   logic          o_call, o_hit, acc0, acc1;
   logic [AW-1:0] o_addr;
   logic [DT-1:0] o_data, o_lkd;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: drive at posedge+1, check at negedge against the model, commit model at posedge.
   task automatic cycle(input logic v0, input logic [AW-1:0] a0, input logic [DT-1:0] d0,
                        input logic v1, input logic [AW-1:0] a1, input logic [DT-1:0] d1,
                        input logic [AW-1:0] lk);
      logic er0, er1, f0, f1, ehit, ecall;
      logic [DT-1:0] elkd;
      ent_t ew;
      enq0_val = v0; enq0_addr = a0; enq0_data = d0;
      enq1_val = v1; enq1_addr = a1; enq1_data = d1;
      lk_addr = lk;
      @(negedge clk);
      er0 = (sb.size() <= DP - 1);
      er1 = (sb.size() <= DP - 2);
      chk("enq0_rdy", enq0_rdy, er0);
      chk("enq1_rdy", enq1_rdy, er1);
      f0 = v0 && er0;
      f1 = v1 && er1;
      acc0 = f0;
      acc1 = f1;
      ehit = 1'b0;
      elkd = '0;
      foreach (sb[i]) if (sb[i].addr == lk) begin ehit = 1'b1; elkd = sb[i].data; end
      chk("lk_hit", lk_hit, ehit);
      chk("lk_data", lk_data, elkd);
      ecall = 1'b0;
      ew = '0;
`ifdef WB_QUEUE_BYPASS_EN
      if (sb.size() == 0 && f0) begin ecall = 1'b1; ew = {a0, d0}; f0 = 1'b0; end else
`endif
      if (sb.size() > 0) begin ecall = 1'b1; ew = sb.pop_front(); end
      chk("wr_call", wr_call, ecall);
      chk("wr_addr", wr_addr, ew.addr);
      chk("wr_data", wr_data, ew.data);
      o_call = wr_call; o_addr = wr_addr; o_data = wr_data;
      o_hit = lk_hit; o_lkd = lk_data;
      if (wr_call) wlog.push_back(wr_data);
      if (f0) sb.push_back({a0, d0});
      if (f1) sb.push_back({a1, d1});
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n, input logic [AW-1:0] lk);
      for (int k = 0; k < n; k++) cycle(1'b0, '0, '0, 1'b0, '0, '0, lk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t tbl[3];
      logic p0, p1;
      int   guard;

      tbl[0] = '{1'b1, 2'd0, 8'h11, 1'b1, 2'd1, 8'h22, 8'h11, 8'h22};
      tbl[1] = '{1'b1, 2'd2, 8'h33, 1'b1, 2'd3, 8'h44, 8'h33, 8'h44};
      tbl[2] = '{1'b1, 2'd0, 8'h55, 1'b1, 2'd1, 8'h66, 8'h55, 8'h66};

      // Reset held for two cycles with enq0_val high.
      #1 reset = 1'b0;
      enq0_val = 1'b1; enq0_addr = 2'd3; enq0_data = 8'h77;
      repeat (2) begin
         @(negedge clk);
         chk("rst_wr_call", wr_call, 1'b0);
         chk("rst_rdy0", enq0_rdy, 1'b0);
         chk("rst_rdy1", enq1_rdy, 1'b0);
         chk("rst_lk_hit", lk_hit, 1'b0);
      end
      #1 reset = 1'b1;
      enq0_val = 1'b0;
      #1;
      chk("rel_rdy0", enq0_rdy, 1'b1);
      chk("rel_rdy1", enq1_rdy, 1'b1);
      @(posedge clk);
      #1;
      idle(2, 2'd3);
      chk("rel_no_write", wlog.size(), 0);

      // Single enqueue.
      cycle(1'b1, 2'd2, 8'hA5, 1'b0, '0, '0, '0);
`ifdef WB_QUEUE_BYPASS_EN
      chk("single_call_t", o_call, 1'b1);
      chk("single_data_t", o_data, 8'hA5);
      idle(1, '0);
      chk("single_call_t1", o_call, 1'b0);
`else
      chk("single_call_t", o_call, 1'b0);
      idle(1, '0);
      chk("single_call_t1", o_call, 1'b1);
      chk("single_addr_t1", o_addr, 2'd2);
      chk("single_data_t1", o_data, 8'hA5);
      idle(1, '0);
      chk("single_call_t2", o_call, 1'b0);
`endif

      // Ordering: each pair held until both halves are accepted.
      wlog.delete();
      for (int r = 0; r < 3; r++) begin
         p0 = tbl[r].v0;
         p1 = tbl[r].v1;
         guard = 0;
         while ((p0 || p1) && guard < 10) begin
            cycle(p0, tbl[r].a0, tbl[r].d0, p1, tbl[r].a1, tbl[r].d1, '0);
            if (acc0) p0 = 1'b0;
            if (acc1) p1 = 1'b0;
            guard++;
         end
         chk("order_accept", guard < 10, 1'b1);
      end
      idle(6, '0);
      chk("order_count", wlog.size(), 6);
      for (int r = 0; r < 3; r++) begin
         if (wlog.size() >= 2 * r + 2) begin
            chk("order_wr0", wlog[2*r], tbl[r].exp_wr0);
            chk("order_wr1", wlog[2*r+1], tbl[r].exp_wr1);
         end
      end

      // Fill with both pipes, then enq0 alone across several pointer wraps.
      for (int k = 0; k < 4; k++)
         cycle(1'b1, AW'(k), DT'(8'h80 + 2*k), 1'b1, AW'(k + 1), DT'(8'h81 + 2*k), AW'(k));
      for (int k = 0; k < 8; k++)
         cycle(1'b1, AW'(k), DT'(8'hC0 + k), 1'b0, '0, '0, AW'(k + 2));
      idle(5, '0);

      // Lookup: two writes to the same address, youngest wins.
      cycle(1'b1, 2'd1, 8'h10, 1'b1, 2'd1, 8'h20, 2'd1);
      idle(1, 2'd1);
      chk("lk_young_hit", o_hit, 1'b1);
      chk("lk_young_data", o_lkd, 8'h20);
      idle(1, 2'd1);
      idle(1, 2'd1);
      chk("lk_empty_hit", o_hit, 1'b0);
      chk("lk_empty_data", o_lkd, 8'h00);

      // Random traffic.
      for (int k = 0; k < 60; k++)
         cycle(1'($urandom_range(1)), AW'($urandom), DT'($urandom),
               1'($urandom_range(1)), AW'($urandom), DT'($urandom), AW'($urandom));
      idle(5, '0);

      // Reset in the middle of draining with count = 3.
      guard = 0;
      while (sb.size() < 3 && guard < 10) begin
         cycle(1'b1, 2'd3, DT'(8'hE0 + guard), 1'b1, 2'd2, DT'(8'hF0 + guard), '0);
         guard++;
      end
      chk("mid_fill", sb.size(), 3);
      #2 reset = 1'b0;
      #1;
      chk("mid_wr_call", wr_call, 1'b0);
      chk("mid_rdy0", enq0_rdy, 1'b0);
      sb.delete();
      wlog.delete();
      enq0_val = 1'b0;
      enq1_val = 1'b0;
      #3 reset = 1'b1;
      @(posedge clk);
      #1;
      idle(4, 2'd3);
      chk("mid_no_stale", wlog.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
